// File: rtl/pipe_stall_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_stall_ctrl_pkg
// Brief    : Shared constants for the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam int STALL_BUS = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

    localparam logic [1:0] PSC_IDLE      = 2'd0;
    localparam logic [1:0] PSC_WAIT_IBUS = 2'd1;
    localparam logic [1:0] PSC_FLUSH     = 2'd2;

    localparam logic [STALL_BUS-1:0] STALL_NONE = {STALL_BUS{NOSTOP}};
    localparam logic [STALL_BUS-1:0] STALL_ALL  = {STALL_BUS{STOP}};
    localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_BUS-1:0] STALL_EXE  = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_BUS-1:0] STALL_IF   = 6'b000011;

    // The deepest requesting stage freezes everything upstream of it.
    function automatic logic [STALL_BUS-1:0] merge_stall(
        input logic req_if,
        input logic req_id,
        input logic req_exe,
        input logic req_mem
    );
        if (req_mem)      return STALL_MEM;
        else if (req_exe) return STALL_EXE;
        else if (req_id)  return STALL_ID;
        else if (req_if)  return STALL_IF;
        else              return STALL_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_if.sv
// ============================================================================
// Module   : pipe_stall_ctrl_if
// Brief    : Stall request / flush bus between pipeline stages and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stall_ctrl_if;
    import pipe_stall_ctrl_pkg::*;

    logic                 stallreq_if;
    logic                 stallreq_id;
    logic                 stallreq_exe;
    logic                 stallreq_mem;
    logic                 exc_req;
    logic [31:0]          exc_pc;
    logic                 ibus_busy;
    logic [STALL_BUS-1:0] stall;
    logic                 flush;
    logic [31:0]          flush_pc;

    modport master (
        output stallreq_if, stallreq_id, stallreq_exe, stallreq_mem,
        output exc_req, exc_pc, ibus_busy,
        input  stall, flush, flush_pc
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_exe, stallreq_mem,
        input  exc_req, exc_pc, ibus_busy,
        output stall, flush, flush_pc
    );

endinterface

`default_nettype wire

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones, with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         inc,
    input  wire logic         clr,
    output logic [W-1:0]      cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Merges stage stall requests and sequences exception flushes,
//            deferring them past outstanding instruction-bus reads.
//            Perf counters built only with PIPE_STALL_CTRL_PERF_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_INIT,
    parameter int          CNT_W    = 32
) (
    input  wire logic           cpu_clk_50M,
    input  wire logic           cpu_rst_n,
    pipe_stall_ctrl_if.slave    bus,
    output logic [CNT_W-1:0]    perf_stall_cnt,
    output logic [CNT_W-1:0]    perf_flush_cnt
);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [31:0]          r_exc_pc;
    logic [31:0]          r_last_pc;
    logic                 w_latch;
    logic [STALL_BUS-1:0] w_stall;
    logic                 w_flush;
    logic [31:0]          w_flush_pc;

    assign w_latch = (r_state == PSC_IDLE) && bus.exc_req && bus.ibus_busy;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= PSC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            PSC_IDLE:      if (w_latch) w_next = PSC_WAIT_IBUS;
            PSC_WAIT_IBUS: if (!bus.ibus_busy) w_next = PSC_FLUSH;
            PSC_FLUSH:     w_next = PSC_IDLE;
            default:       w_next = PSC_IDLE;
        endcase
    end

    always_comb begin
        w_stall    = STALL_NONE;
        w_flush    = 1'b0;
        w_flush_pc = r_last_pc;
        case (r_state)
            PSC_IDLE: begin
                if (bus.exc_req) begin
                    // WB must not retire the excepting instruction while we wait.
                    if (bus.ibus_busy) begin
                        w_stall = STALL_ALL;
                    end else begin
                        w_flush    = 1'b1;
                        w_flush_pc = bus.exc_pc;
                    end
                end else begin
                    w_stall = merge_stall(bus.stallreq_if, bus.stallreq_id,
                                          bus.stallreq_exe, bus.stallreq_mem);
                end
            end
            PSC_WAIT_IBUS: w_stall = STALL_ALL;
            PSC_FLUSH: begin
                w_flush    = 1'b1;
                w_flush_pc = r_exc_pc;
            end
            default: ;
        endcase
        // Keep the combinational paths quiet while reset is held.
        if (!cpu_rst_n) begin
            w_stall    = STALL_NONE;
            w_flush    = 1'b0;
            w_flush_pc = PC_RESET;
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_exc_pc  <= PC_RESET;
            r_last_pc <= PC_RESET;
        end else begin
            if (w_latch) r_exc_pc  <= bus.exc_pc;
            if (w_flush) r_last_pc <= w_flush_pc;
        end
    end

    assign bus.stall    = w_stall;
    assign bus.flush    = w_flush;
    assign bus.flush_pc = w_flush_pc;

`ifdef PIPE_STALL_CTRL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .inc   (|w_stall),
        .clr   (1'b0),
        .cnt   (perf_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (cpu_clk_50M),
        .rst_n (cpu_rst_n),
        .inc   (w_flush),
        .clr   (1'b0),
        .cnt   (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module   : tb_pipe_stall_ctrl
// Brief    : Self-checking bench for pipe_stall_ctrl (honours PIPE_STALL_CTRL_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;
    import pipe_stall_ctrl_pkg::*;

    localparam logic [31:0] PCR = 32'hBFC0_0000;
    localparam int          CW  = 4;
    localparam int          SAT = (1 << CW) - 1;
`ifdef PIPE_STALL_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus();
    logic [CW-1:0] pstall;
    logic [CW-1:0] pflush;

    pipe_stall_ctrl #(.PC_RESET(PCR), .CNT_W(CW)) dut (
        .cpu_clk_50M    (clk),
        .cpu_rst_n      (rst_n),
        .bus            (bus),
        .perf_stall_cnt (pstall),
        .perf_flush_cnt (pflush)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pending exception, scheduled flush, last flush PC, counts.
    bit          m_pend;
    bit          m_flush_next;
    logic [31:0] m_pend_pc;
    logic [31:0] m_last_pc;
    int          m_scnt;
    int          m_fcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend       = 1'b0;
        m_flush_next = 1'b0;
        m_pend_pc    = PCR;
        m_last_pc    = PCR;
        m_scnt       = 0;
        m_fcnt       = 0;
    endtask

    function automatic int cnt_exp(input int v);
        return PERF_ON ? v : 0;
    endfunction

    // req = {mem, exe, id, if}
    task automatic step(input logic [3:0] req, input logic exc,
                        input logic [31:0] pc, input logic busy);
        int          n;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        @(posedge clk);
        #1;
        bus.stallreq_if  = req[0];
        bus.stallreq_id  = req[1];
        bus.stallreq_exe = req[2];
        bus.stallreq_mem = req[3];
        bus.exc_req      = exc;
        bus.exc_pc       = pc;
        bus.ibus_busy    = busy;
        @(negedge clk);
        e_stall = 6'd0;
        e_flush = 1'b0;
        e_pc    = m_last_pc;
        if (m_flush_next) begin
            e_flush      = 1'b1;
            e_pc         = m_pend_pc;
            m_flush_next = 1'b0;
        end else if (m_pend) begin
            e_stall = 6'b111111;
            if (!busy) begin
                m_pend       = 1'b0;
                m_flush_next = 1'b1;
            end
        end else if (exc && !busy) begin
            e_flush = 1'b1;
            e_pc    = pc;
        end else if (exc) begin
            e_stall   = 6'b111111;
            m_pend    = 1'b1;
            m_pend_pc = pc;
        end else begin
            n = req[3] ? 5 : req[2] ? 4 : req[1] ? 3 : req[0] ? 2 : 0;
            e_stall = 6'((1 << n) - 1);
        end
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("flush", 32'(bus.flush), 32'(e_flush));
        chk("flush_pc", bus.flush_pc, e_pc);
        chk("perf_stall_cnt", 32'(pstall), 32'(cnt_exp(m_scnt)));
        chk("perf_flush_cnt", 32'(pflush), 32'(cnt_exp(m_fcnt)));
        if (e_flush) m_last_pc = e_pc;
        if (e_stall != 6'd0 && m_scnt < SAT) m_scnt++;
        if (e_flush && m_fcnt < SAT) m_fcnt++;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic        exc;
        logic [31:0] pc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b0000, 1'b0, 32'h0,          6'b000000, 1'b0, PCR};
        tbl[1] = '{4'b0010, 1'b0, 32'h0,          6'b000111, 1'b0, PCR};
        tbl[2] = '{4'b0110, 1'b0, 32'h0,          6'b001111, 1'b0, PCR};
        tbl[3] = '{4'b1110, 1'b0, 32'h0,          6'b011111, 1'b0, PCR};
        tbl[4] = '{4'b0001, 1'b0, 32'h0,          6'b000011, 1'b0, PCR};
        tbl[5] = '{4'b0000, 1'b1, 32'hBFC0_0380,  6'b000000, 1'b1, 32'hBFC0_0380};
        tbl[6] = '{4'b0000, 1'b0, 32'h0,          6'b000000, 1'b0, 32'hBFC0_0380};
        tbl[7] = '{4'b1110, 1'b1, 32'hBFC0_0400,  6'b000000, 1'b1, 32'hBFC0_0400};
        tbl[8] = '{4'b1000, 1'b0, 32'h0,          6'b011111, 1'b0, 32'hBFC0_0400};

        bus.stallreq_if  = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_exe = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.exc_req      = 1'b0;
        bus.exc_pc       = 32'h0;
        bus.ibus_busy    = 1'b0;
        model_reset();

        #12;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_flush_pc", bus.flush_pc, PCR);
        chk("rst_perf_stall", 32'(pstall), 32'd0);
        chk("rst_perf_flush", 32'(pflush), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].req, tbl[i].exc, tbl[i].pc, 1'b0);
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_flush", i), 32'(bus.flush), 32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d_pc", i), bus.flush_pc, tbl[i].e_pc);
        end

        // Deferred flush: bus busy for 3 cycles, exc_pc changes while waiting.
        step(4'b0000, 1'b1, 32'hBFC0_0180, 1'b1);
        chk("wait0_stall", 32'(bus.stall), 32'h3F);
        step(4'b1111, 1'b1, 32'h1234_5678, 1'b1);
        chk("wait1_stall", 32'(bus.stall), 32'h3F);
        step(4'b0000, 1'b1, 32'h1234_5678, 1'b1);
        chk("wait2_stall", 32'(bus.stall), 32'h3F);
        chk("wait2_flush", 32'(bus.flush), 32'd0);
        step(4'b0000, 1'b1, 32'h1234_5678, 1'b0);
        chk("wait3_stall", 32'(bus.stall), 32'h3F);
        step(4'b0000, 1'b1, 32'h1234_5678, 1'b0);
        chk("dflush_flush", 32'(bus.flush), 32'd1);
        chk("dflush_pc", bus.flush_pc, 32'hBFC0_0180);
        chk("dflush_stall", 32'(bus.stall), 32'd0);
        step(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("post_flush", 32'(bus.flush), 32'd0);
        chk("post_pc_hold", bus.flush_pc, 32'hBFC0_0180);

        // Bus drops in the same cycle the exception arrives.
        step(4'b0000, 1'b0, 32'h0, 1'b1);
        step(4'b0000, 1'b1, 32'hBFC0_0500, 1'b0);
        chk("drop_flush", 32'(bus.flush), 32'd1);
        step(4'b0000, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset in the middle of a deferred flush.
        step(4'b0010, 1'b1, 32'hDEAD_BEE0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(bus.stall), 32'd0);
        chk("arst_flush", 32'(bus.flush), 32'd0);
        chk("arst_pc", bus.flush_pc, PCR);
        chk("arst_perf_stall", 32'(pstall), 32'd0);
        chk("arst_perf_flush", 32'(pflush), 32'd0);
        model_reset();
        @(negedge clk);
        bus.exc_req   = 1'b0;
        bus.ibus_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 1'b0, 32'h0, 1'b0);
            chk("arst_noflush", 32'(bus.flush), 32'd0);
        end

        // Counters: 10 stalled cycles and 2 flushes, then saturation.
        for (int i = 0; i < 10; i++) step(4'($urandom_range(1, 15)), 1'b0, 32'h0, 1'b0);
        step(4'b0000, 1'b1, 32'hBFC0_0600, 1'b0);
        step(4'b0000, 1'b0, 32'h0, 1'b0);
        step(4'b0000, 1'b1, 32'hBFC0_0700, 1'b0);
        step(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("perf_stall_10", 32'(pstall), 32'(PERF_ON ? 10 : 0));
        chk("perf_flush_2", 32'(pflush), 32'(PERF_ON ? 2 : 0));
        for (int i = 0; i < 20; i++) step(4'b1000, 1'b0, 32'h0, 1'b0);
        step(4'b0000, 1'b0, 32'h0, 1'b0);
        chk("perf_stall_sat", 32'(pstall), 32'(PERF_ON ? SAT : 0));

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 7) == 0), $urandom,
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
